servo_pwm_ramp: RTL and testbench
=================================

# servo_pwm_ramp

Parametrised N-channel servo PWM generator with per-channel slew-rate limiting. Each channel holds a target pulse width, written over a simple write port. Once per frame, each channel's output pulse width moves toward its target by at most STEP cycles. This block replaces the fixed three-channel counter/angle/comparator arrangement in the arm top level and drives all servo PWM pins from one shared frame counter.

## Interface
- N_CH, 3: number of servo channels (1..16)
- PERIOD, 1_000_000: frame length in CLK cycles (20 ms at 50 MHz)
- MIN_W, 50_000: minimum legal pulse width in cycles (1 ms)
- MAX_W, 100_000: maximum legal pulse width in cycles (2 ms); MIN_W < MAX_W < PERIOD
- STEP, 500: maximum width change per frame per channel; 0 = no slew limit (jump to target)
- CNT_BITS, 20: frame counter width; 2^CNT_BITS >= PERIOD
- W_BITS, 17: pulse-width field width; 2^W_BITS > MAX_W
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- WR_EN  in  1  write strobe, one write per asserted cycle
- WR_CH  in  max(1,$clog2(N_CH))  channel index for write
- WR_WIDTH  in  W_BITS  requested pulse width in cycles
- PWM  out  N_CH  servo pulse outputs, registered
- FRAME  out  1  one-cycle pulse marking frame start, registered
- SETTLED  out  N_CH  bit i = 1 when current width of channel i equals its target
- CLAMPED  out  1  one-cycle pulse: the previous cycle's accepted write was clamped

## Operation
- Frame counter cnt: 0..PERIOD-1, increments every cycle, wraps PERIOD-1 -> 0.
- Per channel: tgt[i] (target) and cur[i] (current width), both W_BITS wide.
- Write: WR_EN=1 and WR_CH<N_CH -> tgt[WR_CH] <= clamp(WR_WIDTH) to [MIN_W, MAX_W]. CLAMPED=1 next cycle if WR_WIDTH<MIN_W or WR_WIDTH>MAX_W.
- WR_CH>=N_CH: write ignored, no state change, CLAMPED stays 0.
- Ramp update only on the edge where cnt==PERIOD-1, all channels in parallel:
  - cur<tgt: cur += min(STEP, tgt-cur)
  - cur>tgt: cur -= min(STEP, cur-tgt)
  - equal: hold
  - STEP=0: cur <= tgt
- Difference arithmetic is unsigned, computed on the ordered operands; there is no underflow path.
- cur never leaves [MIN_W, MAX_W].
- PWM[i] <= (cnt < cur[i]). cur changes only at the frame boundary, so each frame's pulse is exactly cur[i] cycles, glitch-free.
- FRAME <= (cnt==PERIOD-1).
- SETTLED[i] = (cur[i]==tgt[i]), decoded from registers.

## Timing
- Reset (async assert, sync-released use):
  - cnt=0
  - tgt[i]=cur[i]=CENTER=(MIN_W+MAX_W)/2 (integer)
  - PWM=0, FRAME=0, CLAMPED=0, SETTLED=all 1
- First edge after reset release: PWM rises (cnt was 0). Subsequent PWM rising edges fall on the cycle after FRAME=1.
- FRAME high during the cycle in which cnt==0. PWM rises one cycle after FRAME.
- Write-to-target latency: 1 cycle. Write-to-effect: the first frame boundary whose update edge is strictly after the write edge.
- Write on the same edge as the ramp update: the update uses the old tgt. The new tgt takes effect at the next boundary.
- Two writes to one channel in one frame: the last write wins.
- Reset mid-frame: PWM drops immediately (async); all state returns to reset values.
- Settle time from a step of D cycles: ceil(D/STEP) frames (STEP>0).

## Test plan
Bench parameters: N_CH=3, PERIOD=200, MIN_W=50, MAX_W=100, STEP=10, CNT_BITS=8, W_BITS=8.
- Reset release, no writes -> every channel's PWM high for exactly 75 cycles per 200-cycle frame; SETTLED=3'b111; FRAME period 200 cycles, PWM rises 1 cycle after FRAME.
- Write ch1=100 mid-frame -> SETTLED[1]=0 next cycle; ch1 widths on successive frames 85, 95, 100, then SETTLED[1]=1; ch0 and ch2 unchanged at 75.
- Write ch2=7, then ch0=250 -> CLAMPED pulses once after each write; tgt2=50, tgt0=100; ch2 reaches 50 after 3 frames (65, 55, 50).
- Write ch0=60 on the cycle cnt==199 -> the next frame is still 75; then 65, 60.
- Write WR_CH=3 with WR_WIDTH=90 -> no channel changes, CLAMPED=0, SETTLED stays 3'b111.
- Rebuild with STEP=0, write ch1=95 -> the next frame's ch1 pulse is exactly 95. Assert RST_N low mid-pulse -> PWM=0 in the same cycle; after release, ch1 width is back to 75.

Source files
------------

// File: rtl/servo_pwm_ramp.sv
// N-channel servo PWM generator sharing one frame counter, with per-channel
// slew-rate limiting of the pulse width toward a host-written target.
module servo_pwm_ramp #(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned PERIOD   = 1_000_000,
  parameter int unsigned MIN_W    = 50_000,
  parameter int unsigned MAX_W    = 100_000,
  parameter int unsigned STEP     = 500,
  parameter int unsigned CNT_BITS = 20,
  parameter int unsigned W_BITS   = 17,
  localparam int unsigned CH_BITS = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                WR_EN,
  input  logic [CH_BITS-1:0]  WR_CH,
  input  logic [W_BITS-1:0]   WR_WIDTH,
  output logic [N_CH-1:0]     PWM,
  output logic                FRAME,
  output logic [N_CH-1:0]     SETTLED,
  output logic                CLAMPED
);

  localparam int unsigned SPAN     = MAX_W - MIN_W;
  // A step at least as large as the legal span can never limit a move.
  localparam bit          JUMP     = (STEP == 0) || (STEP >= SPAN);
  localparam int unsigned CMP_BITS = (CNT_BITS > W_BITS) ? CNT_BITS : W_BITS;

  localparam logic [W_BITS-1:0]   MIN_V    = W_BITS'(MIN_W);
  localparam logic [W_BITS-1:0]   MAX_V    = W_BITS'(MAX_W);
  localparam logic [W_BITS-1:0]   CENTER_V = W_BITS'((MIN_W + MAX_W) / 2);
  localparam logic [W_BITS-1:0]   STEP_V   = W_BITS'(JUMP ? 0 : STEP);
  localparam logic [CNT_BITS-1:0] LAST     = CNT_BITS'(PERIOD - 1);

  logic [CNT_BITS-1:0] cnt;
  logic                frame_end;
  logic                wr_ok;
  logic                wr_low;
  logic                wr_high;
  logic [W_BITS-1:0]   wr_val;
  logic [W_BITS-1:0]   tgt     [N_CH];
  logic [W_BITS-1:0]   cur     [N_CH];
  logic [W_BITS-1:0]   cur_nxt [N_CH];

  always_comb begin
    frame_end = (cnt == LAST);
    wr_ok     = WR_EN && ({1'b0, WR_CH} < (CH_BITS + 1)'(N_CH));
    wr_low    = (WR_WIDTH < MIN_V);
    wr_high   = (WR_WIDTH > MAX_V);
    wr_val    = wr_low ? MIN_V : (wr_high ? MAX_V : WR_WIDTH);
  end

  // Differences are taken on ordered operands, so no wrap is possible.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      cur_nxt[i] = cur[i];
      if (JUMP) begin
        cur_nxt[i] = tgt[i];
      end else if (cur[i] < tgt[i]) begin
        cur_nxt[i] = ((tgt[i] - cur[i]) > STEP_V) ? (cur[i] + STEP_V) : tgt[i];
      end else if (cur[i] > tgt[i]) begin
        cur_nxt[i] = ((cur[i] - tgt[i]) > STEP_V) ? (cur[i] - STEP_V) : tgt[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt     <= '0;
      FRAME   <= 1'b0;
      CLAMPED <= 1'b0;
      PWM     <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        tgt[i] <= CENTER_V;
        cur[i] <= CENTER_V;
      end
    end else begin
      cnt     <= frame_end ? '0 : cnt + CNT_BITS'(1);
      FRAME   <= frame_end;
      CLAMPED <= wr_ok && (wr_low || wr_high);
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (wr_ok && (WR_CH == CH_BITS'(i))) tgt[i] <= wr_val;
        // The ramp reads tgt before this edge's write lands.
        if (frame_end) cur[i] <= cur_nxt[i];
        PWM[i] <= (CMP_BITS'(cnt) < CMP_BITS'(cur[i]));
      end
    end
  end

  always_comb begin
    SETTLED = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      SETTLED[i] = (cur[i] == tgt[i]);
    end
  end

endmodule

// File: tb/tb_servo_pwm_ramp.sv
// Directed bench for servo_pwm_ramp: one slew-limited instance and one
// STEP=0 instance sharing clock, reset and write bus.
`timescale 1ns/1ps
module tb_servo_pwm_ramp;

  localparam int unsigned PERIOD = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en_a;
  logic       wr_en_b;
  logic [1:0] wr_ch;
  logic [7:0] wr_width;
  logic [2:0] pwm_a, settled_a, pwm_b, settled_b;
  logic       frame_a, clamped_a, frame_b, clamped_b;

  always #5 clk = ~clk;

  servo_pwm_ramp #(
    .N_CH(3), .PERIOD(200), .MIN_W(50), .MAX_W(100), .STEP(10),
    .CNT_BITS(8), .W_BITS(8)
  ) dut_a (
    .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en_a), .WR_CH(wr_ch),
    .WR_WIDTH(wr_width), .PWM(pwm_a), .FRAME(frame_a),
    .SETTLED(settled_a), .CLAMPED(clamped_a)
  );

  servo_pwm_ramp #(
    .N_CH(3), .PERIOD(200), .MIN_W(50), .MAX_W(100), .STEP(0),
    .CNT_BITS(8), .W_BITS(8)
  ) dut_b (
    .CLK(clk), .RST_N(rst_n), .WR_EN(wr_en_b), .WR_CH(wr_ch),
    .WR_WIDTH(wr_width), .PWM(pwm_b), .FRAME(frame_b),
    .SETTLED(settled_b), .CLAMPED(clamped_b)
  );

  typedef struct {
    logic [1:0] ch;
    logic [7:0] width;
    logic       clamped;
    logic [2:0] settled;
    int         w0;
    int         w1;
    int         w2;
  } vec_t;

  vec_t vecs [11];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   w_a [3];
  int   w_b [3];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; waits for FRAME, then counts PWM-high cycles over one frame.
  task automatic measure();
    int guard = 0;
    while (!frame_a && guard < 2 * PERIOD) begin
      @(negedge clk);
      guard++;
    end
    check("frame_found", int'(frame_a), 1);
    for (int c = 0; c < 3; c++) begin
      w_a[c] = 0;
      w_b[c] = 0;
    end
    for (int k = 0; k < PERIOD; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        w_a[c] += int'(pwm_a[c]);
        w_b[c] += int'(pwm_b[c]);
      end
    end
  endtask

  task automatic check_widths_a(input string name, input int e0, input int e1, input int e2);
    check({name, "_ch0"}, w_a[0], e0);
    check({name, "_ch1"}, w_a[1], e1);
    check({name, "_ch2"}, w_a[2], e2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_a(input logic [1:0] ch, input logic [7:0] w);
    wr_ch    = ch;
    wr_width = w;
    wr_en_a  = 1'b1;
    @(negedge clk);
    wr_en_a = 1'b0;
  endtask

  initial begin
    int period;

    vecs[0]  = '{2'd0, 8'd75,  1'b0, 3'b111, 75, 75, 75};
    vecs[1]  = '{2'd1, 8'd100, 1'b0, 3'b101, 75, 85, 75};
    vecs[2]  = '{2'd2, 8'd7,   1'b1, 3'b011, 75, 75, 65};
    vecs[3]  = '{2'd0, 8'd250, 1'b1, 3'b110, 85, 75, 75};
    vecs[4]  = '{2'd3, 8'd90,  1'b0, 3'b111, 75, 75, 75};
    vecs[5]  = '{2'd1, 8'd50,  1'b0, 3'b101, 75, 65, 75};
    vecs[6]  = '{2'd2, 8'd49,  1'b1, 3'b011, 75, 75, 65};
    vecs[7]  = '{2'd0, 8'd101, 1'b1, 3'b110, 85, 75, 75};
    vecs[8]  = '{2'd1, 8'd0,   1'b1, 3'b101, 75, 65, 75};
    vecs[9]  = '{2'd3, 8'd0,   1'b0, 3'b111, 75, 75, 75};
    vecs[10] = '{2'd0, 8'd80,  1'b0, 3'b110, 80, 75, 75};

    rst_n    = 1'b0;
    wr_en_a  = 1'b0;
    wr_en_b  = 1'b0;
    wr_ch    = '0;
    wr_width = '0;

    // Reset state and frame/PWM phase
    repeat (2) @(negedge clk);
    check("rst_pwm",     int'(pwm_a),     0);
    check("rst_frame",   int'(frame_a),   0);
    check("rst_clamped", int'(clamped_a), 0);
    check("rst_settled", int'(settled_a), 7);
    check("rst_pwm_b",   int'(pwm_b),     0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_edge_pwm",   int'(pwm_a),   7);
    check("first_edge_frame", int'(frame_a), 0);
    period = 0;
    while (!frame_a && period < 2 * PERIOD) begin
      @(negedge clk);
      period++;
    end
    check("pwm_low_in_frame_cycle", int'(pwm_a), 0);
    @(negedge clk);
    check("pwm_rise_after_frame", int'(pwm_a), 7);
    period = 1;
    while (!frame_a && period < 2 * PERIOD) begin
      @(negedge clk);
      period++;
    end
    check("frame_period", period, 200);
    measure();
    check_widths_a("idle", 75, 75, 75);
    check("idle_width_b", w_b[1], 75);
    check("idle_settled", int'(settled_a), 7);

    // Ramp ch1 up to 100
    repeat (20) @(negedge clk);
    write_a(2'd1, 8'd100);
    check("up_settled_after_wr", int'(settled_a), 5);
    check("up_clamped", int'(clamped_a), 0);
    measure();
    check_widths_a("up_f1", 75, 85, 75);
    measure();
    check_widths_a("up_f2", 75, 95, 75);
    measure();
    check_widths_a("up_f3", 75, 100, 75);
    check("up_settled_end", int'(settled_a), 7);

    // Clamped writes
    repeat (20) @(negedge clk);
    write_a(2'd2, 8'd7);
    check("clamp_lo_pulse", int'(clamped_a), 1);
    @(negedge clk);
    check("clamp_lo_drop", int'(clamped_a), 0);
    write_a(2'd0, 8'd250);
    check("clamp_hi_pulse", int'(clamped_a), 1);
    @(negedge clk);
    check("clamp_hi_drop", int'(clamped_a), 0);
    measure();
    check_widths_a("clamp_f1", 85, 100, 65);
    measure();
    check_widths_a("clamp_f2", 95, 100, 55);
    measure();
    check_widths_a("clamp_f3", 100, 100, 50);
    check("clamp_settled", int'(settled_a), 7);

    // Write on the update edge uses the old target
    do_reset();
    measure();
    check_widths_a("sync", 75, 75, 75);
    repeat (199) @(negedge clk);
    write_a(2'd0, 8'd60);
    check("boundary_frame_aligned", int'(frame_a), 1);
    measure();
    check_widths_a("boundary_f1", 75, 75, 75);
    measure();
    check_widths_a("boundary_f2", 65, 75, 75);
    measure();
    check_widths_a("boundary_f3", 60, 75, 75);

    // Out-of-range channel
    repeat (20) @(negedge clk);
    write_a(2'd3, 8'd90);
    check("oob_clamped", int'(clamped_a), 0);
    check("oob_settled", int'(settled_a), 7);
    measure();
    check_widths_a("oob", 60, 75, 75);

    // Single-write vectors, each from a fresh reset
    for (int v = 0; v < 11; v++) begin
      do_reset();
      @(negedge clk);
      write_a(vecs[v].ch, vecs[v].width);
      check($sformatf("vec%0d_clamped", v), int'(clamped_a), int'(vecs[v].clamped));
      check($sformatf("vec%0d_settled", v), int'(settled_a), int'(vecs[v].settled));
      @(negedge clk);
      check($sformatf("vec%0d_clamped_drop", v), int'(clamped_a), 0);
      measure();
      check_widths_a($sformatf("vec%0d", v), vecs[v].w0, vecs[v].w1, vecs[v].w2);
    end

    // STEP=0 jump, then async reset mid-pulse
    do_reset();
    measure();
    repeat (20) @(negedge clk);
    wr_ch    = 2'd1;
    wr_width = 8'd95;
    wr_en_b  = 1'b1;
    @(negedge clk);
    wr_en_b = 1'b0;
    check("jump_settled_b", int'(settled_b), 5);
    measure();
    check("jump_width_b", w_b[1], 95);
    check("jump_width_b_ch0", w_b[0], 75);
    check_widths_a("jump_a_untouched", 75, 75, 75);
    repeat (30) @(negedge clk);
    check("mid_pulse_b", int'(pwm_b[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm_b", int'(pwm_b), 0);
    check("async_rst_pwm_a", int'(pwm_a), 0);
    @(negedge clk);
    check("async_rst_settled_b", int'(settled_b), 7);
    @(negedge clk);
    rst_n = 1'b1;
    measure();
    check("post_rst_width_b", w_b[1], 75);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
